// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame master: state encoding, SPI mode constants
// ({cpol,cpha}) and the default frame width.
package spi_pkg;

    localparam int DEFAULT_FRAME_W = 40;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        SETUP       = 3'd1,
        SHIFT_LEAD  = 3'd2,
        SHIFT_TRAIL = 3'd3,
        HOLD        = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sclk_gen.sv
// Half-period timer for the SPI frame master: counts clk_div+1 cycles per SCLK half
// and flags the end of each half as a leading- or trailing-edge strobe.
module spi_sclk_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    input  logic [DIV_W-1:0] reload_div,
    input  logic             run,
    input  logic             in_lead,
    output logic             tick,
    output logic             lead_edge,
    output logic             trail_edge
);

    logic [DIV_W-1:0] cnt;

    // load seeds the first half straight from the port, later halves use the latched divider
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_div;
        end else if (run) begin
            if (cnt == '0) begin
                cnt <= reload_div;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    assign tick       = run && (cnt == '0);
    assign lead_edge  = tick && !in_lead;
    assign trail_edge = tick && in_lead;

endmodule

// File: rtl/spi_frame_master.sv
// SPI master shifting one FRAME_W-bit frame MSB first in any of the four SPI modes.
// Define SPI_FRAME_MASTER_RX_EN to build the MISO receive register; otherwise rx_data is 0.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter  int FRAME_W = DEFAULT_FRAME_W,
    parameter  int DIV_W   = 8,
    parameter  int NUM_CS  = 4,
    localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    localparam int CNT_W   = $clog2(FRAME_W + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic [CS_W-1:0]    cs_sel,
    input  logic [DIV_W-1:0]   clk_div,
    input  logic               cpol,
    input  logic               cpha,
    output logic               busy,
    output logic               done,
    output logic [NUM_CS-1:0]  spi_cs_l,
    output logic               spi_sclk,
    output logic               spi_data,
    input  logic               spi_miso,
    output logic [FRAME_W-1:0] rx_data,
    output logic [CNT_W-1:0]   counter
);

    state_t             state;
    logic [FRAME_W-1:0] tx_sr;
    logic [DIV_W-1:0]   div_q;
    logic               cpol_q;
    logic               cpha_q;
    logic               hold_end;
    logic               accept;
    logic               tick;
    logic               lead_edge;
    logic               trail_edge;

    assign accept = (state == IDLE) && start;

    // Out-of-range selects leave every chip select deasserted
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (sel == CS_W'(i)) v[i] = 1'b0;
        end
        return v;
    endfunction

    spi_sclk_gen #(.DIV_W(DIV_W)) u_sclk_gen (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .load_div   (clk_div),
        .reload_div (div_q),
        .run        (state != IDLE),
        .in_lead    (state == SHIFT_LEAD),
        .tick       (tick),
        .lead_edge  (lead_edge),
        .trail_edge (trail_edge)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            spi_cs_l <= '1;
            spi_sclk <= 1'b0;
            spi_data <= 1'b0;
            counter  <= '0;
            tx_sr    <= '0;
            div_q    <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            hold_end <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        spi_cs_l <= cs_decode(cs_sel);
                        counter  <= CNT_W'(FRAME_W);
                        tx_sr    <= frame_in;
                        spi_data <= frame_in[FRAME_W-1];
                        div_q    <= clk_div;
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        spi_sclk <= cpol;
                        hold_end <= 1'b0;
                    end
                end
                SETUP: begin
                    if (lead_edge) begin
                        state    <= SHIFT_LEAD;
                        spi_sclk <= ~cpol_q;
                    end
                end
                SHIFT_LEAD: begin
                    // cpha=0 presents the next bit on the trailing edge
                    if (trail_edge) begin
                        state    <= SHIFT_TRAIL;
                        spi_sclk <= cpol_q;
                        if (!cpha_q && counter > CNT_W'(1)) begin
                            tx_sr    <= tx_sr << 1;
                            spi_data <= tx_sr[FRAME_W-2];
                        end
                    end
                end
                SHIFT_TRAIL: begin
                    // cpha=1 presents the next bit on the following leading edge
                    if (lead_edge) begin
                        counter <= counter - CNT_W'(1);
                        if (counter == CNT_W'(1)) begin
                            state <= HOLD;
                        end else begin
                            state    <= SHIFT_LEAD;
                            spi_sclk <= ~cpol_q;
                            if (cpha_q) begin
                                tx_sr    <= tx_sr << 1;
                                spi_data <= tx_sr[FRAME_W-2];
                            end
                        end
                    end
                end
                HOLD: begin
                    // One idle half period, then a single closing cycle that releases the slave
                    if (hold_end) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        spi_cs_l <= '1;
                        hold_end <= 1'b0;
                    end else if (tick) begin
                        hold_end <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    spi_cs_l <= '1;
                    hold_end <= 1'b0;
                end
            endcase
        end
    end

`ifdef SPI_FRAME_MASTER_RX_EN
    logic [FRAME_W-1:0] rx_sr;
    logic               sample;

    // cpha=0 samples on entering a lead half, cpha=1 on entering a trail half
    assign sample = cpha_q ? trail_edge
                           : (lead_edge && (state == SETUP ||
                                            (state == SHIFT_TRAIL && counter > CNT_W'(1))));

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sr   <= '0;
            rx_data <= '0;
        end else begin
            if (sample) begin
                rx_sr <= {rx_sr[FRAME_W-2:0], spi_miso};
            end
            if (state == HOLD && hold_end) begin
                rx_data <= rx_sr;
            end
        end
    end
`else
    logic unused_miso;
    assign unused_miso = spi_miso;
    assign rx_data     = '0;
`endif

endmodule

// File: tb/tb_spi_frame_master.sv
// Self-checking bench for spi_frame_master: table-driven frames in all four modes plus
// start-hold, mid-frame reset and out-of-range chip-select sequences.
module tb_spi_frame_master;
    import spi_pkg::*;

    localparam int FW = 40;

    typedef struct {
        logic [FW-1:0] frame;
        logic [1:0]    cs;
        logic [7:0]    div;
        logic [1:0]    mode;
        logic [3:0]    exp_cs;
        logic [2:0]    exp_cs3;
        int            exp_lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [FW-1:0] frame_in;
    logic [1:0]    cs_sel;
    logic [7:0]    clk_div;
    logic          cpol;
    logic          cpha;
    logic          spi_miso;
    logic          miso_tog = 1'b0;

    logic          busy, done, spi_sclk, spi_data;
    logic [3:0]    spi_cs_l;
    logic [FW-1:0] rx_data;
    logic [5:0]    counter;

    logic          busy3, done3, sclk3, data3;
    logic [2:0]    cs3_l;
    logic [FW-1:0] rx3;
    logic [5:0]    counter3;

    int   compared   = 0;
    int   mismatched = 0;
    vec_t vecs[4];

    always #5 clk = ~clk;

`ifdef SPI_FRAME_MASTER_RX_EN
    assign spi_miso = spi_data;
`else
    assign spi_miso = miso_tog;
    always @(negedge clk) miso_tog = ~miso_tog;
`endif

    spi_frame_master #(.FRAME_W(FW), .DIV_W(8), .NUM_CS(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .frame_in (frame_in),
        .cs_sel   (cs_sel),
        .clk_div  (clk_div),
        .cpol     (cpol),
        .cpha     (cpha),
        .busy     (busy),
        .done     (done),
        .spi_cs_l (spi_cs_l),
        .spi_sclk (spi_sclk),
        .spi_data (spi_data),
        .spi_miso (spi_miso),
        .rx_data  (rx_data),
        .counter  (counter)
    );

    // Three chip selects leave cs_sel=3 out of range on a 2-bit select
    spi_frame_master #(.FRAME_W(FW), .DIV_W(8), .NUM_CS(3)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .frame_in (frame_in),
        .cs_sel   (cs_sel),
        .clk_div  (clk_div),
        .cpol     (cpol),
        .cpha     (cpha),
        .busy     (busy3),
        .done     (done3),
        .spi_cs_l (cs3_l),
        .spi_sclk (sclk3),
        .spi_data (data3),
        .spi_miso (spi_miso),
        .rx_data  (rx3),
        .counter  (counter3)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [FW-1:0] f, input logic [1:0] cs,
                                 input logic [7:0] d, input logic [1:0] m);
        @(negedge clk);
        frame_in = f;
        cs_sel   = cs;
        clk_div  = d;
        {cpol, cpha} = m;
        start    = 1'b1;
    endtask

    // Called #1 after the accepting edge; follows the frame to its done pulse
    task automatic monitor_frame(input vec_t v, input bit hold_start, input string tag);
        int            cycles;
        int            leads;
        int            cs_bad;
        int            busy_bad;
        logic          prev;
        logic          is_lead;
        logic [FW-1:0] mosi;

        start = hold_start;
        if (!hold_start) begin
            frame_in = ~v.frame;
            cs_sel   = ~v.cs;
            clk_div  = ~v.div;
            {cpol, cpha} = ~v.mode;
        end
        checkOutput({tag, ".busy_on"}, busy, 1);
        checkOutput({tag, ".count_init"}, counter, FW);
        checkOutput({tag, ".mosi_msb"}, spi_data, v.frame[FW-1]);
        checkOutput({tag, ".sclk_setup"}, spi_sclk, v.mode[1]);

        prev = spi_sclk; mosi = '0; leads = 0; cs_bad = 0; busy_bad = 0; cycles = 0;
        while (cycles < 2000) begin
            @(posedge clk); #1;
            cycles++;
            if (done) break;
            if (spi_cs_l !== v.exp_cs || cs3_l !== v.exp_cs3) cs_bad++;
            if (busy !== 1'b1) busy_bad++;
            if (spi_sclk !== prev) begin
                is_lead = (spi_sclk !== v.mode[1]);
                if (is_lead) leads++;
                if (is_lead == !v.mode[0]) mosi = {mosi[FW-2:0], spi_data};
                prev = spi_sclk;
            end
        end

        checkOutput({tag, ".done"}, done, 1);
        checkOutput({tag, ".done3"}, done3, 1);
        checkOutput({tag, ".latency"}, cycles, v.exp_lat);
        checkOutput({tag, ".sclk_pulses"}, leads, FW);
        checkOutput({tag, ".mosi_bits"}, mosi, v.frame);
        checkOutput({tag, ".cs_during"}, cs_bad, 0);
        checkOutput({tag, ".busy_during"}, busy_bad, 0);
        checkOutput({tag, ".busy_off"}, busy, 0);
        checkOutput({tag, ".cs_release"}, spi_cs_l, 4'hF);
        checkOutput({tag, ".cs3_release"}, cs3_l, 3'h7);
        checkOutput({tag, ".count_end"}, counter, 0);
        checkOutput({tag, ".sclk_idle"}, spi_sclk, v.mode[1]);
        checkOutput({tag, ".mosi_last"}, spi_data, v.frame[0]);
`ifdef SPI_FRAME_MASTER_RX_EN
        checkOutput({tag, ".rx_loop"}, rx_data, v.frame);
`else
        checkOutput({tag, ".rx_zero"}, rx_data, 0);
`endif
        frame_in = v.frame;
        cs_sel   = v.cs;
        clk_div  = v.div;
        {cpol, cpha} = v.mode;
        if (!hold_start) begin
            @(posedge clk); #1;
            checkOutput({tag, ".done_pulse"}, done, 0);
            checkOutput({tag, ".mosi_hold"}, spi_data, v.frame[0]);
            checkOutput({tag, ".idle_busy"}, busy, 0);
        end
    endtask

    task automatic run_frame(input vec_t v, input bit hold_start, input string tag);
        applyStimulus(v.frame, v.cs, v.div, v.mode);
        @(posedge clk); #1;
        monitor_frame(v, hold_start, tag);
    endtask

    initial begin
        int cycles;
        int dones;
        int busy_seen;

        vecs[0] = '{40'hFF123401AB, 2'd2, 8'd0, MODE0, 4'b1011, 3'b011, 83};
        vecs[1] = '{40'hA5A5A5A5A5, 2'd0, 8'd3, MODE3, 4'b1110, 3'b110, 329};
        vecs[2] = '{40'h0123456788, 2'd1, 8'd1, MODE1, 4'b1101, 3'b101, 165};
        vecs[3] = '{40'h8000000001, 2'd3, 8'd2, MODE2, 4'b0111, 3'b111, 247};

        reset = 1'b1; start = 1'b0; frame_in = '0; cs_sel = '0; clk_div = '0;
        cpol = 1'b0; cpha = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.cs", spi_cs_l, 4'hF);
        checkOutput("rst.cs3", cs3_l, 3'h7);
        checkOutput("rst.sclk", spi_sclk, 0);
        checkOutput("rst.mosi", spi_data, 0);
        checkOutput("rst.counter", counter, 0);
        checkOutput("rst.rx", rx_data, 0);
        reset = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_frame(vecs[i], 1'b0, $sformatf("vec%0d", i));
        end

        // start held high: one frame, then the next accepted in the done cycle
        run_frame(vecs[0], 1'b1, "hold1");
        @(posedge clk); #1;
        monitor_frame(vecs[0], 1'b0, "hold2");

        // reset in the middle of a frame
        applyStimulus(vecs[0].frame, vecs[0].cs, vecs[0].div, vecs[0].mode);
        @(posedge clk); #1;
        start = 1'b0;
        cycles = 0;
        while (counter !== 6'd20 && cycles < 500) begin
            @(posedge clk); #1;
            cycles++;
        end
        checkOutput("abort.reach20", counter, 20);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort.busy", busy, 0);
        checkOutput("abort.cs", spi_cs_l, 4'hF);
        checkOutput("abort.counter", counter, 0);
        checkOutput("abort.sclk", spi_sclk, 0);
        checkOutput("abort.done", done, 0);
        dones = 0; busy_seen = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (done) dones++;
            if (busy) busy_seen++;
        end
        checkOutput("abort.no_done", dones, 0);
        checkOutput("abort.stay_idle", busy_seen, 0);
        run_frame(vecs[0], 1'b0, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
